// File: rtl/sha_compre.sv
// One SHA-256 compression round: combines a..h with K_t and W_t and registers
// the next working variables. There is no control logic and no state besides the output registers.
module sha_compre (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ckey,
  input  logic [31:0] warray,
  input  logic [31:0] ain,
  input  logic [31:0] bin,
  input  logic [31:0] cin,
  input  logic [31:0] din,
  input  logic [31:0] ein,
  input  logic [31:0] fin,
  input  logic [31:0] gin,
  input  logic [31:0] hin,
  output logic [31:0] aout,
  output logic [31:0] bout,
  output logic [31:0] cout,
  output logic [31:0] dout,
  output logic [31:0] eout,
  output logic [31:0] fout,
  output logic [31:0] gout,
  output logic [31:0] hout
);

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  logic [31:0] sum1;
  logic [31:0] choose;
  logic [31:0] sum0;
  logic [31:0] major;
  logic [31:0] temp1;
  logic [31:0] temp2;

  // Round function terms; every 32-bit add wraps, so carries out of bit 31 are dropped
  always_comb begin
    sum1   = rotr(ein, 6) ^ rotr(ein, 11) ^ rotr(ein, 25);
    choose = (ein & fin) ^ (~ein & gin);
    sum0   = rotr(ain, 2) ^ rotr(ain, 13) ^ rotr(ain, 22);
    major  = (ain & bin) ^ (ain & cin) ^ (bin & cin);
    temp1  = hin + sum1 + choose + ckey + warray;
    temp2  = sum0 + major;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aout <= 32'h0;
      bout <= 32'h0;
      cout <= 32'h0;
      dout <= 32'h0;
      eout <= 32'h0;
      fout <= 32'h0;
      gout <= 32'h0;
      hout <= 32'h0;
    end else begin
      aout <= temp1 + temp2;
      bout <= ain;
      cout <= bin;
      dout <= cin;
      eout <= din + temp1;
      fout <= ein;
      gout <= fin;
      hout <= gin;
    end
  end

endmodule

// File: tb/tb_sha_compre.sv
// Directed bench for sha_compre: table of hand-computed round vectors, plus
// sequences for reset behaviour and back-to-back rounds.
module tb_sha_compre;

  logic        clk;
  logic        rst;
  logic [31:0] ckey, warray;
  logic [31:0] ain, bin, cin, din, ein, fin, gin, hin;
  logic [31:0] aout, bout, cout, dout, eout, fout, gout, hout;

  int vectorCount;
  int missCount;

  typedef struct {
    string             tag;
    logic [31:0]       key;
    logic [31:0]       word;
    logic [7:0][31:0]  vin;
    logic [7:0][31:0]  vexp;
  } vector_t;

  vector_t vecs[4];

  localparam logic [7:0][31:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  sha_compre dut (
    .clk(clk), .rst(rst), .ckey(ckey), .warray(warray),
    .ain(ain), .bin(bin), .cin(cin), .din(din),
    .ein(ein), .fin(fin), .gin(gin), .hin(hin),
    .aout(aout), .bout(bout), .cout(cout), .dout(dout),
    .eout(eout), .fout(fout), .gout(gout), .hout(hout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [31:0] k, input logic [31:0] w,
                               input logic [7:0][31:0] v);
    ckey = k;
    warray = w;
    {ain, bin, cin, din, ein, fin, gin, hin} = v;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    vectorCount++;
    if (actual !== required) begin
      missCount++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, required);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0][31:0] required);
    logic [7:0][31:0] got;
    got = {aout, bout, cout, dout, eout, fout, gout, hout};
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("%s.out%0d", tag, 7 - i), got[i], required[i]);
  endtask

  initial begin
    vectorCount = 0;
    missCount = 0;

    vecs[0] = '{"hello", 32'h428a2f98, 32'h68656c6f, IV,
                {32'h646df4bc, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                 32'h012d4f11, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab}};
    vecs[1] = '{"abc", 32'h428a2f98, 32'h61626380, IV,
                {32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                 32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab}};
    vecs[2] = '{"wrap", 32'hffffffff, 32'hffffffff, {8{32'hffffffff}},
                {32'hfffffff9, 32'hffffffff, 32'hffffffff, 32'hffffffff,
                 32'hfffffffa, 32'hffffffff, 32'hffffffff, 32'hffffffff}};
    vecs[3] = '{"zero", 32'h0, 32'h0, {8{32'h0}}, {8{32'h0}}};

    // Reset held low with nonzero inputs and a running clock
    rst = 1'b0;
    applyStimulus(vecs[0].key, vecs[0].word, vecs[0].vin);
    #1;
    checkAll("rst_pre", {8{32'h0}});
    repeat (2) @(posedge clk);
    #1;
    checkAll("rst_held", {8{32'h0}});

    // Release between edges; first edge loads a normal result
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkAll("rst_first", vecs[0].vexp);

    // Asynchronous reset mid-cycle, no clock edge in between
    #2;
    rst = 1'b0;
    #1;
    checkAll("rst_async", {8{32'h0}});
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].key, vecs[i].word, vecs[i].vin);
      @(posedge clk);
      #1;
      checkAll(vecs[i].tag, vecs[i].vexp);
    end

    // Inputs changing between edges must not reach the outputs
    @(negedge clk);
    applyStimulus(vecs[2].key, vecs[2].word, vecs[2].vin);
    #1;
    checkOutput("hold_a", aout, 32'h0);
    checkOutput("hold_e", eout, 32'h0);

    // Back-to-back rounds alternating the message word
    @(negedge clk);
    applyStimulus(32'h428a2f98, 32'h68656c6f, IV);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      warray = (i % 2 == 0) ? 32'h61626380 : 32'h68656c6f;
      checkOutput($sformatf("b2b%0d_a", i), aout, (i % 2 == 0) ? 32'h646df4bc : 32'h5d6aebcd);
      checkOutput($sformatf("b2b%0d_e", i), eout, (i % 2 == 0) ? 32'h012d4f11 : 32'hfa2a4622);
      checkOutput($sformatf("b2b%0d_b", i), bout, 32'h6a09e667);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
